id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC, operands and immediate.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports id_valid  input  1, and id_pc, id_rs1_data, id_rs2_data, id_imm  input  XLEN: decode-stage instruction and its data.
REQ-005 SHALL have ports id_rs1, id_rs2, id_rd  input  5, id_funct3  input  3, id_funct7b5  input  1: decode-stage fields.
REQ-006 SHALL have ports id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  input  1, and id_aluop  input  2: control-unit outputs.
REQ-007 SHALL have port flush  input  1  kill the decode-stage instruction (taken branch).
REQ-008 SHALL have port stall  output  1  load-use stall to control unit, PC and IF/ID register.
REQ-009 SHALL have ports ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop  output  (widths as REQ-004..006): registered EX-stage copies.

Function
REQ-010 stall SHALL be combinational: id_valid & ex_valid & ex_memread & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & !flush.
REQ-011 Each edge, priority flush > stall > normal SHALL select the next EX contents.
REQ-012 Normal: all ex_* SHALL capture the id_* inputs, ex_valid <= id_valid; latency exactly one cycle.
REQ-013 Bubble (flush or stall): ex_valid and all seven control outputs SHALL become 0; data/field outputs SHALL become 0.
REQ-014 id_valid=0 in normal capture SHALL force all control outputs to 0 regardless of id_* control inputs.
REQ-015 A load-use stall SHALL last exactly one cycle: after the bubble ex_memread=0, so stall deasserts with unchanged ID inputs.
REQ-016 Back-to-back loads with dependent consumers SHALL each produce exactly one bubble.
REQ-017 rd = x0 SHALL never cause a stall.
REQ-018 flush and a stall condition in the same cycle SHALL produce one bubble with stall=0.

Reset
REQ-019 rst=1 SHALL immediately (asynchronously) clear every register: ex_valid=0, all control and data outputs 0; stall consequently 0.
REQ-020 Reset release SHALL resume normal capture on the first following edge; reset asserted mid-stall SHALL drop stall immediately.

Configuration
REQ-021 Macro ID_EX_PERF_EN, when defined, SHALL add outputs stall_cnt and flush_cnt (16 bits each), incremented on each edge where stall resp. flush is 1, saturating at 0xFFFF, cleared by rst.
REQ-022 Without ID_EX_PERF_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-023 A shared package SHALL hold the ctrl_t packed struct (branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop[1:0]), CTRL_NOP constant (all zero) and opcode constants.
REQ-024 Hazard detection SHALL be a sub-module load_use_detect (purely combinational, REQ-010/017); the register stage instantiates it.

Verification
REQ-025 Normal: id_valid=1, id_pc=0x100, id_regwrite=1, id_aluop=2'b10 -> next cycle ex_pc=0x100, ex_regwrite=1, ex_aluop=2'b10, ex_valid=1, stall=0.
REQ-026 Load-use: EX holds lw rd=5; ID add rs1=5 -> stall=1 for one cycle, EX bubble (ex_valid=0), then add captured, stall=0.
REQ-027 x0 load: EX lw rd=0, ID rs1=0 -> stall=0, normal capture.
REQ-028 Flush with hazard: flush=1 while REQ-026 condition holds -> stall=0, EX bubble, stall_cnt unchanged, flush_cnt +1 (with ID_EX_PERF_EN).
REQ-029 Async reset: assert rst mid-cycle with ex_valid=1 -> ex_valid=0 and all outputs 0 before next edge.
REQ-030 Saturation (ID_EX_PERF_EN): force 65536 stall cycles -> stall_cnt=0xFFFF, stays 0xFFFF on further stalls.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline register: control bundle, NOP value, RV32I opcodes.
package id_ex_stage_pkg;

   typedef struct packed {
      logic       branch;
      logic       memread;
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic       regwrite;
      logic [1:0] aluop;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector; a flush suppresses the stall.
module load_use_detect (
   input  logic       i_id_valid,
   input  logic [4:0] i_id_rs1,
   input  logic [4:0] i_id_rs2,
   input  logic       i_ex_valid,
   input  logic       i_ex_memread,
   input  logic [4:0] i_ex_rd,
   input  logic       i_flush,
   output logic       o_stall
);

   logic w_rd_nz;
   logic w_match;

   // x0 is hardwired zero, so a load into it never creates a dependency
   assign w_rd_nz = (i_ex_rd != 5'd0);
   assign w_match = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
   assign o_stall = i_id_valid & i_ex_valid & i_ex_memread & w_rd_nz & w_match & ~i_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush.
// Optional ID_EX_PERF_EN adds saturating 16-bit stall/flush event counters.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7b5,
   input  logic            id_branch,
   input  logic            id_memread,
   input  logic            id_memtoreg,
   input  logic            id_memwrite,
   input  logic            id_alusrc,
   input  logic            id_regwrite,
   input  logic [1:0]      id_aluop,
   input  logic            flush,
   output logic            stall,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic            ex_branch,
   output logic            ex_memread,
   output logic            ex_memtoreg,
   output logic            ex_memwrite,
   output logic            ex_alusrc,
   output logic            ex_regwrite,
   output logic [1:0]      ex_aluop
`ifdef ID_EX_PERF_EN
   ,
   output logic [15:0]     stall_cnt,
   output logic [15:0]     flush_cnt
`endif
);

   logic            r_valid;
   ctrl_t           r_ctrl;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_rs1_data;
   logic [XLEN-1:0] r_rs2_data;
   logic [XLEN-1:0] r_imm;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic [4:0]      r_rd;
   logic [2:0]      r_funct3;
   logic            r_funct7b5;

   ctrl_t           w_id_ctrl;
   logic            w_stall;
   logic            w_bubble;

   assign w_id_ctrl = '{branch:   id_branch,
                        memread:  id_memread,
                        memtoreg: id_memtoreg,
                        memwrite: id_memwrite,
                        alusrc:   id_alusrc,
                        regwrite: id_regwrite,
                        aluop:    id_aluop};

   load_use_detect u_lud (
      .i_id_valid   (id_valid),
      .i_id_rs1     (id_rs1),
      .i_id_rs2     (id_rs2),
      .i_ex_valid   (r_valid),
      .i_ex_memread (r_ctrl.memread),
      .i_ex_rd      (r_rd),
      .i_flush      (flush),
      .o_stall      (w_stall)
   );

   assign w_bubble = flush | w_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_ctrl     <= CTRL_NOP;
         r_pc       <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_funct3   <= '0;
         r_funct7b5 <= 1'b0;
      end else if (w_bubble) begin
         r_valid    <= 1'b0;
         r_ctrl     <= CTRL_NOP;
         r_pc       <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_funct3   <= '0;
         r_funct7b5 <= 1'b0;
      end else begin
         // an invalid slot must not carry live control into EX
         r_valid    <= id_valid;
         r_ctrl     <= id_valid ? w_id_ctrl : CTRL_NOP;
         r_pc       <= id_pc;
         r_rs1_data <= id_rs1_data;
         r_rs2_data <= id_rs2_data;
         r_imm      <= id_imm;
         r_rs1      <= id_rs1;
         r_rs2      <= id_rs2;
         r_rd       <= id_rd;
         r_funct3   <= id_funct3;
         r_funct7b5 <= id_funct7b5;
      end
   end

`ifdef ID_EX_PERF_EN
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
         if (flush && r_flush_cnt != 16'hFFFF)   r_flush_cnt <= r_flush_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

   assign stall       = w_stall;
   assign ex_valid    = r_valid;
   assign ex_pc       = r_pc;
   assign ex_rs1_data = r_rs1_data;
   assign ex_rs2_data = r_rs2_data;
   assign ex_imm      = r_imm;
   assign ex_rs1      = r_rs1;
   assign ex_rs2      = r_rs2;
   assign ex_rd       = r_rd;
   assign ex_funct3   = r_funct3;
   assign ex_funct7b5 = r_funct7b5;
   assign ex_branch   = r_ctrl.branch;
   assign ex_memread  = r_ctrl.memread;
   assign ex_memtoreg = r_ctrl.memtoreg;
   assign ex_memwrite = r_ctrl.memwrite;
   assign ex_alusrc   = r_ctrl.alusrc;
   assign ex_regwrite = r_ctrl.regwrite;
   assign ex_aluop    = r_ctrl.aluop;

endmodule
